ram_port_master: RTL

RAM_PORT_MASTER -- requirements
Module: ram_port_master

---
 rtl/ram_master_pkg.sv | 17 +
 rtl/ram_port_master.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/ram_master_pkg.sv
// ram_master_pkg
//   Shared definitions for the RAM port master: default RAM geometry and the
//   burst FSM state type.
package ram_master_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_STREAM,
        DONE
    } state_t;

endpackage

// File: rtl/ram_port_master.sv
// ram_port_master
//   Burst master for a single-port synchronous RAM with a shared tri-state
//   data bus. A request (start address, beats-minus-one, direction) is taken
//   in IDLE. It is then run as a write burst, paced by wr_valid, or as a read
//   burst that streams one beat per cycle onto rd_data.
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     req_valid/ready     burst request handshake (ready only in IDLE)
//     req_write           1 = write burst, 0 = read burst
//     req_addr, req_len   start address, beats minus one
//     wr_data/valid/ready write-beat handshake
//     rd_data, rd_valid   read beat, no backpressure
//     done                one-cycle burst-complete pulse
//     cs, wr_en, out_en   RAM strobes
//     address             RAM address
//     data_inout          shared RAM data bus
module ram_port_master
    import ram_master_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              cs,
    output logic              wr_en,
    output logic              out_en,
    output logic [ADDR_W-1:0] address,
    inout  wire  [DATA_W-1:0] data_inout
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] beat_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              done_q;

    logic              wr_strobe;
    logic              last_beat;
    logic              more_issue;

    // Direction is latched by the choice of WR vs RD_ISSUE on acceptance.
    assign wr_strobe  = (state == WR) && wr_valid;
    assign last_beat  = (beat_q == len_q);
    // Reads run one address ahead of the captured beat: RD_ISSUE puts out
    // beat 0's address and every RD_STREAM cycle puts out the next one until
    // the last beat's address has been issued, after which it holds.
    assign more_issue = ((ADDR_W + 1)'(beat_q) + (ADDR_W + 1)'(1)) < (ADDR_W + 1)'(len_q);

    always_comb begin
        req_ready = (state == IDLE);
        wr_ready  = (state == WR);
        cs        = wr_strobe || (state == RD_ISSUE) || (state == RD_STREAM);
        wr_en     = wr_strobe;
        out_en    = (state == RD_STREAM);
        address   = addr_q;
        rd_data   = rd_data_q;
        rd_valid  = rd_valid_q;
        done      = done_q;
    end

    // The bus is driven only while a write beat is being strobed.
    assign data_inout = (cs && wr_en) ? wr_data : 'z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        len_q  <= req_len;
                        beat_q <= '0;
                        state  <= req_write ? WR : RD_ISSUE;
                    end
                end
                WR: begin
                    if (wr_valid) begin
                        if (last_beat) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                            beat_q <= beat_q + ADDR_W'(1);
                        end
                    end
                end
                RD_ISSUE: begin
                    if (len_q != '0) begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                    state <= RD_STREAM;
                end
                RD_STREAM: begin
                    rd_data_q  <= data_inout;
                    rd_valid_q <= 1'b1;
                    if (more_issue) begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                    if (last_beat) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        beat_q <= beat_q + ADDR_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
